// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Purpose  : Multi-cycle radix-2 restoring divider for DIV/DIVU. It produces
//             one quotient bit per falling clock edge and supports signed
//             (two's complement) or unsigned operation, chosen per request.
//             It flags divide-by-zero and uses a start/busy/done handshake.
//  Ports    : clock_i      - clock; all state updates on the falling edge
//             reset_i      - synchronous, active-high reset
//             start_i      - operation request, sampled only in IDLE
//             is_signed_i  - 1 = signed DIV, 0 = unsigned DIVU
//             dividend_i   - dividend, sampled with start_i
//             divisor_i    - divisor, sampled with start_i
//             q_o / r_o    - quotient / remainder, held until next start
//             busy_o       - high while an operation is in flight
//             done_o       - one-cycle pulse when q_o/r_o become valid
//             div_zero_o   - last operation had a zero divisor
//  Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic [WIDTH-1:0] res_q_q, res_q_d;
  logic [WIDTH-1:0] res_r_q, res_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Operand magnitudes. Negating the most-negative value yields 2**(WIDTH-1),
  // which is exactly right when the result is read as unsigned.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = is_signed_i & dividend_i[WIDTH-1];
  assign b_neg = is_signed_i & divisor_i[WIDTH-1];
  assign a_mag = a_neg ? -dividend_i : dividend_i;
  assign b_mag = b_neg ? -divisor_i  : divisor_i;

  // Shifted partial remainder is one bit wider so the compare cannot overflow.
  logic [WIDTH:0] rem_sh, dvs_ext;
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign dvs_ext = {1'b0, dvs_q};

  always_ff @(negedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      res_q_q    <= '0;
      res_r_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      res_q_q    <= res_q_d;
      res_r_q    <= res_r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    res_q_d    = res_q_q;
    res_r_d    = res_r_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dz_d       = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          busy_d = 1'b1;
          cnt_d  = CNT_INIT;
          dvs_d  = b_mag;
          if (divisor_i == '0) begin
            // Preload so the sign-fix step passes q=all ones, r=dividend.
            quo_d      = '1;
            rem_d      = dividend_i;
            sign_quo_d = 1'b0;
            sign_rem_d = 1'b0;
            dz_d       = 1'b1;
            state_d    = S_FIX;
          end else begin
            quo_d      = a_mag;
            rem_d      = '0;
            sign_quo_d = a_neg ^ b_neg;
            sign_rem_d = a_neg;
            dz_d       = 1'b0;
            state_d    = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (rem_sh >= dvs_ext) begin
          rem_d = WIDTH'(rem_sh - dvs_ext);
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_q_d = sign_quo_q ? -quo_q : quo_q;
        res_r_d = sign_rem_q ? -rem_q : rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign q_o        = res_q_q;
  assign r_o        = res_r_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_iter
//  Purpose  : Self-checking bench for div_iter, with a 32-bit and an 8-bit
//             instance. Directed cases plus random operands compared against
//             an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        s32, sg32;
  logic [31:0] a32, b32, q32, r32;
  logic        busy32, done32, dz32;

  logic        s8, sg8;
  logic [7:0]  a8, b8, q8, r8;
  logic        busy8, done8, dz8;

  int checks = 0;
  int errors = 0;

  div_iter #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .clock_i(clock), .reset_i(reset), .start_i(s32), .is_signed_i(sg32),
    .dividend_i(a32), .divisor_i(b32), .q_o(q32), .r_o(r32),
    .busy_o(busy32), .done_o(done32), .div_zero_o(dz32)
  );

  div_iter #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clock_i(clock), .reset_i(reset), .start_i(s8), .is_signed_i(sg8),
    .dividend_i(a8), .divisor_i(b8), .q_o(q8), .r_o(r8),
    .busy_o(busy8), .done_o(done8), .div_zero_o(dz8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic void model(input int w, input bit sg, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r, output logic z);
    longint sa, sb, qq, rr;
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if ((b & m) == 32'd0) begin
      q = m;
      r = a & m;
      z = 1'b1;
      return;
    end
    sa = longint'(a & m);
    sb = longint'(b & m);
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    qq = sa / sb;
    rr = sa % sb;
    q = qq[31:0] & m;
    r = rr[31:0] & m;
    z = 1'b0;
  endfunction

  logic [31:0] oq, orr;
  logic        obusy, odone, odz;
  task automatic sample(input int w);
    if (w == 32) begin
      oq = q32; orr = r32; obusy = busy32; odone = done32; odz = dz32;
    end else begin
      oq = {24'd0, q8}; orr = {24'd0, r8}; obusy = busy8; odone = done8; odz = dz8;
    end
  endtask

  // Issue one operation (inputs driven at posedge, DUT samples at negedge)
  // and wait for done with a bounded cycle budget.
  task automatic op(input int w, input bit sg, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er, input logic ez,
                    input bit drop, input string tag);
    int  n;
    int  lat;
    bit  busy_ok;
    if (w == 32) begin s32 = 1'b1; sg32 = sg; a32 = a; b32 = b; end
    else begin s8 = 1'b1; sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; end
    @(negedge clock);
    @(posedge clock);
    s32 = 1'b0; s8 = 1'b0;
    a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = (((w == 32) ? b : (b & 32'hFF)) == 32'd0) ? 1 : w + 1;
    busy_ok = 1'b1;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      sample(w);
      if (!obusy) busy_ok = 1'b0;
      @(negedge clock);
      @(posedge clock);
      sample(w);
      if (odone) begin
        n = i;
        break;
      end
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_q"}, oq, eq);
    check({tag, "_r"}, orr, er);
    check({tag, "_dz"}, {31'd0, odz}, {31'd0, ez});
    if (drop) begin
      check({tag, "_busyoff"}, {31'd0, obusy}, 32'd0);
      @(negedge clock);
      @(posedge clock);
      sample(w);
      check({tag, "_donedrop"}, {31'd0, odone}, 32'd0);
      check({tag, "_qhold"}, oq, eq);
    end
  endtask

  task automatic op_model(input int w, input bit sg, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
    logic [31:0] eq, er;
    logic        ez;
    model(w, sg, a, b, eq, er, ez);
    op(w, sg, a, b, eq, er, ez, 1'b0, tag);
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] ra, rb;
    reset = 1'b1;
    s32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
    s8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clock);
    @(posedge clock);
    check("rst_q", q32, 32'd0);
    check("rst_r", r32, 32'd0);
    check("rst_busy", {31'd0, busy32}, 32'd0);
    check("rst_done", {31'd0, done32}, 32'd0);
    check("rst_dz", {31'd0, dz32}, 32'd0);
    check("rst_q8", {24'd0, q8}, 32'd0);
    reset = 1'b0;
    @(posedge clock);

    // Directed 32-bit cases
    op(32, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, "divu_100_7");
    op(32, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_m7_2");
    op(32, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, "div_7_m2");
    op(32, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1, "divu_5_0");
    op(32, 1'b1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "div_min_0");
    op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, "div_ovf");
    op(32, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, "divu_max_1");

    // Start pulsed at edge 10 of an operation is ignored
    s32 = 1'b1; sg32 = 1'b0; a32 = 32'd1000; b32 = 32'd3;
    @(negedge clock);
    @(posedge clock);
    s32 = 1'b0;
    repeat (9) @(negedge clock);
    @(posedge clock);
    s32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
    @(negedge clock);
    @(posedge clock);
    s32 = 1'b0;
    n = 0;
    for (int i = 11; i <= 60; i++) begin
      @(negedge clock);
      @(posedge clock);
      if (done32) begin
        n = i;
        break;
      end
    end
    check("ign_lat", n, 32'd33);
    check("ign_q", q32, 32'd333);
    check("ign_r", r32, 32'd1);

    // Reset at edge 15 aborts the operation
    s32 = 1'b1; sg32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h10;
    @(negedge clock);
    @(posedge clock);
    s32 = 1'b0;
    repeat (14) @(negedge clock);
    @(posedge clock);
    check("abort_busy_pre", {31'd0, busy32}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    @(posedge clock);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy32}, 32'd0);
    check("abort_q", q32, 32'd0);
    check("abort_r", r32, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      if (done32) seen = 1'b1;
    end
    check("abort_nodone", {31'd0, seen}, 32'd0);

    // Back-to-back: each op is issued in the cycle its predecessor's done is high
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = (i % 5 == 0) ? ($urandom & 32'hFF) : $urandom;
      op_model(32, 1'($urandom), ra, rb, "rand32");
    end

    // 8-bit instance: boundary cases then random pairs
    op(8, 1'b1, 32'h80, 32'hFF, 32'h80, 32'd0, 1'b0, 1'b1, "d8_ovf");
    op(8, 1'b1, 32'h80, 32'h00, 32'hFF, 32'h80, 1'b1, 1'b0, "d8_zero");
    op(8, 1'b1, 32'hF9, 32'h02, 32'hFD, 32'hFF, 1'b0, 1'b0, "d8_m7_2");
    op(8, 1'b0, 32'hFF, 32'h01, 32'hFF, 32'h00, 1'b0, 1'b0, "d8u_max");
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'hFF;
      rb = (i % 50 == 0) ? 32'd0 : ($urandom & 32'hFF);
      op_model(8, 1'(i & 1), ra, rb, "rand8");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
